// File: rtl/mod_updown_counter_pkg.sv
// Shared counter definitions: direction encodings and the modulo step function
// used by mod_updown_counter and future timer blocks.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int unsigned MAX_WIDTH = 32;

  // {wrap_flag, next_q}; next_q is always in 0..modulus-1 for in-range q
  typedef struct packed {
    logic        wrap;
    logic [31:0] q;
  } step_t;

  // modulus is 33 bits so that a full 2**32 range can be expressed
  function automatic step_t next_count(input logic [31:0] q,
                                       input logic        up_dn,
                                       input logic [32:0] modulus);
    step_t       r;
    logic [32:0] last;
    last   = modulus - 33'd1;
    r.wrap = 1'b0;
    r.q    = q;
    if (up_dn == DIR_UP) begin
      if ({1'b0, q} == last) begin
        r.wrap = 1'b1;
        r.q    = '0;
      end else begin
        r.q = q + 32'd1;
      end
    end else begin
      if (q == '0) begin
        r.wrap = 1'b1;
        r.q    = last[31:0];
      end else begin
        r.q = q - 32'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_updown_counter_count_step.sv
// Combinational next-count, wrap and terminal-count logic for mod_updown_counter.
// COUNTER_SAT_EN selects saturating instead of modulo behaviour at the ends.
module mod_count_step
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MODULUS = 256
) (
  input  logic [WIDTH-1:0] q,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] next_q,
  output logic             wrap_next,
  output logic             tc
);

  localparam logic [32:0]      MOD33 = 33'(MODULUS);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 64'd1);

  step_t s;
  logic  unused_hi;

  always_comb begin
    s = next_count(32'(q), up_dn, MOD33);
`ifdef COUNTER_SAT_EN
    // an end-of-range step holds instead of wrapping
    next_q    = s.wrap ? q : s.q[WIDTH-1:0];
    wrap_next = 1'b0;
`else
    next_q    = s.q[WIDTH-1:0];
    wrap_next = s.wrap;
`endif
    tc = en & ((up_dn & (q == LAST)) | (~up_dn & (q == '0)));
  end

  assign unused_hi = ^s.q;

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulo counter with clear, load, enable, tc and wrap pulse.
// Build with COUNTER_SAT_EN defined for saturating (non-wrapping) operation.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH     = 8,
  parameter longint unsigned MODULUS   = 256,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be in 2..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (RESET_VAL >= MODULUS) begin : g_bad_reset
    $error("mod_updown_counter: RESET_VAL must be below MODULUS");
  end

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] step_q;
  logic             step_wrap;
  logic [WIDTH-1:0] load_q;

  mod_count_step #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_step (
    .q         (q),
    .en        (en),
    .up_dn     (up_dn),
    .next_q    (step_q),
    .wrap_next (step_wrap),
    .tc        (tc)
  );

  // out-of-range loads clamp to the top of the count range
  assign load_q = (64'(load_val) < MODULUS) ? load_val : LAST;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= RST_Q;
      wrap <= 1'b0;
    end else if (clr) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= load_q;
      wrap <= 1'b0;
    end else if (en) begin
      q    <= step_q;
      wrap <= step_wrap;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter (WIDTH=4, MODULUS=10, RESET_VAL=3)
// plus a two-stage decimal cascade; follows COUNTER_SAT_EN when defined.
module tb_mod_updown_counter;

  localparam int W = 4;
  localparam int M = 10;
  localparam int R = 3;
`ifdef COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, en, up_dn, clr, load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         tc, wrap;

  logic         c_en;
  logic [W-1:0] q1, q2;
  logic         tc1, tc2, wrap1, wrap2;

  int errors = 0;
  int checks = 0;
  int mq, mw;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(W), .MODULUS(M), .RESET_VAL(R)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .q(q), .tc(tc), .wrap(wrap)
  );

  mod_updown_counter #(.WIDTH(W), .MODULUS(M), .RESET_VAL(0)) stage1 (
    .clk(clk), .rst(rst), .en(c_en), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .q(q1), .tc(tc1), .wrap(wrap1)
  );

  mod_updown_counter #(.WIDTH(W), .MODULUS(M), .RESET_VAL(0)) stage2 (
    .clk(clk), .rst(rst), .en(tc1), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .q(q2), .tc(tc2), .wrap(wrap2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock of the reference counter: tc checked before the edge, q/wrap after.
  task automatic tick(input string tag);
    int etc;
    int nxt;
    etc = (en && ((up_dn && mq == M - 1) || (!up_dn && mq == 0))) ? 1 : 0;
    #1;
    check({tag, ".tc"}, 32'(tc), etc);
    if (clr) begin
      mq = 0; mw = 0;
    end else if (load) begin
      mq = (int'(load_val) < M) ? int'(load_val) : M - 1;
      mw = 0;
    end else if (en) begin
      nxt = up_dn ? mq + 1 : mq - 1;
      if (nxt >= 0 && nxt < M) begin
        mq = nxt; mw = 0;
      end else if (SAT) begin
        mw = 0;
      end else begin
        mq = (nxt + M) % M; mw = 1;
      end
    end else begin
      mw = 0;
    end
    @(posedge clk);
    #1;
    check({tag, ".q"}, 32'(q), mq);
    check({tag, ".wrap"}, 32'(wrap), mw);
  endtask

  initial begin
    int wraps;
    int val;
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
    load_val = '0; c_en = 1'b0;
    mq = R; mw = 0;

    #3;
    check("reset.q", 32'(q), R);
    check("reset.wrap", 32'(wrap), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    repeat (5) tick("hold");

    en = 1'b1; up_dn = 1'b1;
    repeat (8) tick("up");

    up_dn = 1'b0;
    repeat (3) tick("down");

    load = 1'b1; load_val = 4'd12;
    tick("load_clamp");
    clr = 1'b1;
    tick("clr_load");
    clr = 1'b0; load = 1'b0;

    up_dn = 1'b0;
    repeat (3) tick("down_from0");

    for (int i = 0; i < 300; i++) begin
      en       = 1'($urandom_range(0, 3) != 0);
      up_dn    = 1'($urandom_range(0, 1));
      clr      = 1'($urandom_range(0, 15) == 0);
      load     = 1'($urandom_range(0, 7) == 0);
      load_val = 4'($urandom_range(0, 15));
      tick("rand");
    end

    // park at 9, step up so a wrap pulse is pending, then reset mid-cycle
    clr = 1'b0; load = 1'b1; load_val = 4'd9; en = 1'b0;
    tick("pre_rst_load");
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick("pre_rst_step");
    #2;
    rst = 1'b1;
    #1;
    mq = R; mw = 0;
    check("async_rst.q", 32'(q), R);
    check("async_rst.wrap", 32'(wrap), 0);
    @(posedge clk); #1;
    check("rst_held.q", 32'(q), R);
    rst = 1'b0; en = 1'b0;

`ifndef COUNTER_SAT_EN
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; c_en = 1'b1;
    wraps = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      val = 10 * int'(q2) + int'(q1);
      check("cascade.value", val, k % 100);
      if (wrap2 === 1'b1) wraps++;
    end
    check("cascade.q1_final", 32'(q1), 0);
    check("cascade.q2_final", 32'(q2), 0);
    check("cascade.wrap2_last", 32'(wrap2), 1);
    check("cascade.wrap2_count", wraps, 1);
    c_en = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised synchronous up/down counter with programmable modulus, parallel load, synchronous clear and enable.
- Successor to the team's fixed 2-bit ripple counter. All state bits share one clock, so there are no derived clocks.
- Provides a combinational terminal-count output for cascading and a registered wrap pulse.
- Used as a general event/timebase counter in the FPGA labs designs.

Parameters:
- WIDTH, 8, counter width in bits; range 2..32.
- MODULUS, 256, count range 0..MODULUS-1; range 2 <= MODULUS <= 2**WIDTH.
- RESET_VAL, 0, value of q after rst; must be < MODULUS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; a step occurs only on cycles with en=1.
- up_dn  input  1  direction: 1 = increment, 0 = decrement.
- clr  input  1  synchronous clear to 0; highest synchronous priority.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse on wrap-around.

Behaviour:
- Reset: rst=1 forces q=RESET_VAL and wrap=0 immediately, independent of clk.
  - Reset deassertion is synchronised externally; no internal synchroniser.
- Synchronous priority per rising edge: clr > load > en > hold.
- clr=1: q<=0, wrap<=0. Ignores load, en and up_dn.
- load=1 (clr=0): q<=load_val if load_val < MODULUS, else q<=MODULUS-1 (clamp). wrap<=0.
- en=1 with up_dn=1: q<=q+1 if q != MODULUS-1; else q<=0 and wrap<=1.
- en=1 with up_dn=0: q<=q-1 if q != 0; else q<=MODULUS-1 and wrap<=1.
- en=0, no clr/load: q holds, wrap<=0.
- wrap is high for exactly one cycle, in the cycle after the wrapping edge. Any non-wrapping edge clears it.
- tc = en & ((up_dn & q==MODULUS-1) | (~up_dn & q==0)).
  - Combinational, zero latency; intended to drive the en input of a cascaded stage.
  - tc is not gated by clr/load.
- Latency: q updates on the edge following the control inputs, one cycle.
- Arithmetic: compare and step at WIDTH bits.
  - When MODULUS == 2**WIDTH, up-wrap is natural overflow, but is still detected by the compare so wrap asserts.
  - No out-of-range q is reachable.
- Direction change mid-count: takes effect on the next edge; no pipeline state.
- Simultaneous load and en: load wins, no step, no wrap.
- Reset mid-count: q returns to RESET_VAL asynchronously; any pending wrap pulse is cancelled.

Optional Feature:
- Macro: COUNTER_SAT_EN.
- Defined: saturating mode.
  - Up at MODULUS-1 and down at 0 hold q; no wrap-around occurs.
  - wrap is tied to 0.
  - tc behaves as specified above, so it stays high while saturated and enabled.
- Undefined: modulo wrap behaviour as specified above.
- Load clamping is identical in both modes.

Decomposition:
- Package counter_pkg:
  - localparam-style constants DIR_UP=1'b1, DIR_DN=1'b0.
  - A function next_count(q, up_dn, modulus) returning {wrap_flag, next_q}, shared by this block and future timer blocks.
- One sub-module: mod_count_step.
  - Purely combinational next-state/wrap/tc logic.
  - The top keeps the q and wrap registers plus the priority mux.
- Parameter legality is checked with an elaboration-time error on MODULUS > 2**WIDTH, MODULUS < 2, or RESET_VAL >= MODULUS.

Test Plan:
All scenarios use WIDTH=4, MODULUS=10, RESET_VAL=3 unless stated.
1. Assert rst between clock edges -> q=3 and wrap=0 immediately. Release rst, en=0 for 5 cycles -> q stays 3.
2. en=1, up_dn=1 for 8 cycles from 3 -> q: 4..9 then 0,1.
   - tc=1 only while q=9.
   - wrap=1 exactly in the cycle q=0 first appears.
3. en=1, up_dn=0 from q=1 -> q: 0, 9, 8.
   - tc=1 while q=0.
   - wrap pulses one cycle with q=9.
4. load=1, load_val=12, with en=1 -> q=9 (clamped), no wrap. Next, clr=1 and load=1 together -> q=0.
5. Cascade two instances, with stage-2 en = stage-1 tc, and count up 100 cycles from 0 -> {q2,q1} reads 10 decimal steps per stage-2 increment; final state q2=0, q1=0 with stage-2 wrap pulsing once.
6. Compile with COUNTER_SAT_EN, count up 12 cycles from 3 -> q sticks at 9, wrap never 1, tc=1 from first q=9.
   - Down from 0 -> q holds 0.
